// File: rtl/wave_sample_pacer.sv
// rtl/wave_sample_pacer.sv - paces FIFO samples to a DAC at a programmable rate
// Read-latency pipe keeps tick-to-strobe latency fixed whether the sample is fresh or repeated.
module wave_sample_pacer #(
    parameter int p_nbit_d    = 16,
    parameter int p_rd_lat    = 2,
    parameter int p_nbit_div  = 16,
    parameter int p_nbit_ucnt = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [p_nbit_div-1:0]  div,
    input  logic                   clr,
    output logic                   fifo_rd,
    input  logic [p_nbit_d-1:0]    fifo_rdata,
    input  logic                   fifo_empty,
    output logic [p_nbit_d-1:0]    dac_data,
    output logic                   dac_strobe,
    output logic                   underflow,
    output logic [p_nbit_ucnt-1:0] ucnt,
    output logic                   busy
);

    typedef enum logic {
        s_idle = 1'b0,
        s_run  = 1'b1
    } state_t;

    state_t                state;
    logic [p_nbit_div-1:0] cnt;
    logic [p_rd_lat-1:0]   pipe_v;
    logic [p_rd_lat-1:0]   pipe_f;
    logic                  tick;
    logic                  uflow_evt;

    assign tick      = (state == s_run) && (cnt == '0);
    assign fifo_rd   = tick && !fifo_empty;
    assign uflow_evt = tick && fifo_empty;
    assign busy      = (state == s_run) || (|pipe_v) || dac_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= s_idle;
            cnt   <= '0;
        end else begin
            case (state)
                s_idle: begin
                    cnt <= '0;
                    if (en) begin
                        state <= s_run;
                    end
                end
                s_run: begin
                    if (!en) begin
                        state <= s_idle;
                        cnt   <= '0;
                    end else if (tick) begin
                        cnt <= div;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= s_idle;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Token: v marks a tick, f marks that the tick actually issued a FIFO read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v     <= '0;
            pipe_f     <= '0;
            dac_strobe <= 1'b0;
            dac_data   <= '0;
        end else begin
            pipe_v[0] <= tick;
            pipe_f[0] <= tick && !fifo_empty;
            for (int i = 1; i < p_rd_lat; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_f[i] <= pipe_f[i-1];
            end
            dac_strobe <= pipe_v[p_rd_lat-1];
            if (pipe_v[p_rd_lat-1] && pipe_f[p_rd_lat-1]) begin
                dac_data <= fifo_rdata;
            end
        end
    end

    // An underflow in the same cycle as clr wins and restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
            ucnt      <= '0;
        end else if (uflow_evt) begin
            underflow <= 1'b1;
            if (clr) begin
                ucnt <= p_nbit_ucnt'(1);
            end else if (ucnt != '1) begin
                ucnt <= ucnt + 1'b1;
            end
        end else if (clr) begin
            underflow <= 1'b0;
            ucnt      <= '0;
        end
    end

endmodule

// File: doc/wave_sample_pacer.md
# wave_sample_pacer

Downstream consumer of the waveform sample FIFO. It pulls samples from `sync_fifo` at a programmable sample rate and presents each sample to the DAC interface as a held data word plus a one-cycle strobe. It compensates for the FIFO's configurable read latency, holds the last sample on underflow, and counts underflow events.

## Interface
Parameters:
- `p_nbit_d`, 16: sample width; must equal the FIFO's `p_nbit_d`.
- `p_rd_lat`, 2: cycles from `fifo_rd` high to valid `fifo_rdata`. Legal values are 1 (FIFO without output register) and 2 (FIFO with output register).
- `p_nbit_div`, 16: width of the rate divider.
- `p_nbit_ucnt`, 8: width of the underflow counter.

Ports:
- `clk`, input, 1: single clock for the block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: run enable.
- `div`, input, `p_nbit_div`: sample period minus one, so ticks occur every `div`+1 cycles.
- `clr`, input, 1: clears `underflow` and `ucnt`.
- `fifo_rd`, output, 1: read request to the FIFO `rd`.
- `fifo_rdata`, input, `p_nbit_d`: FIFO read data.
- `fifo_empty`, input, 1: FIFO empty flag.
- `dac_data`, output, `p_nbit_d`: current sample, held between strobes.
- `dac_strobe`, output, 1: one-cycle pulse when `dac_data` updates or is re-issued.
- `underflow`, output, 1: sticky flag, set when a tick finds the FIFO empty.
- `ucnt`, output, `p_nbit_ucnt`: saturating count of underflow ticks.
- `busy`, output, 1: high in RUN or while reads are in flight.

## Operation
- Two-state FSM:
  - IDLE -> RUN when `en`=1 is sampled; the rate counter `cnt` is loaded with 0.
  - RUN -> IDLE when `en`=0 is sampled.
- Tick = RUN & (`cnt`==0).
  - On a tick, `cnt` reloads from `div`; otherwise `cnt` decrements.
  - `div` is sampled only at reload, so a mid-run change takes effect after the current period.
  - In IDLE, `cnt` is held at 0.
- `fifo_rd` = tick & ~`fifo_empty`. This output is combinational and is never asserted while the FIFO is empty.
- Each tick pushes a token {v=1, fresh=~`fifo_empty`} into a `p_rd_lat`-deep shift pipe. Non-tick cycles push v=0.
- When a token exits the pipe with v=1:
  - `dac_strobe` goes high in the next cycle.
  - If fresh=1, `dac_data` is updated from `fifo_rdata`; if fresh=0, `dac_data` is unchanged (the last sample is repeated).
  - The DAC rate therefore stays constant through underflow.
- Underflow event = tick & `fifo_empty`. It sets `underflow` and increments `ucnt`, saturating at all-ones.
- `clr` clears `underflow` and `ucnt`. If `clr` coincides with an underflow event, the event wins: `underflow`=1, `ucnt`=1.
- Leaving RUN stops new ticks only; in-flight tokens drain normally. `busy` = RUN | (any pipe v bit) | `dac_strobe` pending.
- Re-entering RUN while tokens are draining is legal; the pipe continues unaffected.
- `div`=0 gives one tick per cycle, and back-to-back `fifo_rd` is permitted. The FIFO's empty flag is valid each cycle for this case.

## Timing
- Reset (asynchronous, `rst_n`=0) forces:
  - FSM to IDLE; `cnt`=0; pipe cleared.
  - `fifo_rd`=0, `dac_data`=0, `dac_strobe`=0, `underflow`=0, `ucnt`=0, `busy`=0.
  - Assertion mid-run discards in-flight tokens immediately.
  - Release is synchronous to `clk` through the standard reset synchroniser upstream.
- `en` sampled high at edge E: cycle E+1 is RUN and is the first tick.
- Tick in cycle T:
  - `fifo_rd` is high in cycle T.
  - `fifo_rdata` is valid in cycle T+`p_rd_lat`.
  - `dac_data` and `dac_strobe` are updated and visible in cycle T+`p_rd_lat`+1.
- Latency from tick to strobe = `p_rd_lat`+1 cycles, fixed, for both fresh and repeated samples.
- Strobe spacing equals `div`+1 cycles in steady state.
- `en` sampled low at edge F: no tick from cycle F+1 onward. The last possible strobe is at cycle F+`p_rd_lat`+1, and `busy` falls the cycle after it.
- `underflow` and `ucnt` update at the edge ending the tick cycle, i.e. visible in T+1.

## Test plan
1. Reset: drive `rst_n`=0 asynchronously mid-cycle -> all outputs read 0 immediately, FSM is IDLE, and no `fifo_rd` occurs until `en`=1.
2. Paced read: `p_rd_lat`=2, `div`=3, FIFO preloaded with 0x0001..0x0004, `en`=1 -> `fifo_rd` pulses every 4 cycles starting at the first RUN cycle; `dac_strobe` follows each pulse 3 cycles later with `dac_data` = 1, 2, 3, 4 in order.
3. Underflow: continue scenario 2 with no more writes -> strobes continue every 4 cycles with `dac_data`=0x0004, no `fifo_rd` is issued, `underflow`=1, and `ucnt` increments per tick, saturating at 255 after 255 underflow ticks.
4. Clear collision: assert `clr` in the same cycle as an underflow tick -> next cycle shows `underflow`=1 and `ucnt`=1. Assert `clr` alone -> both read 0.
5. Stop mid-flight: `div`=0, `p_rd_lat`=1, FIFO holding 10 samples, deassert `en` after 3 reads -> exactly 3 strobes with samples 1..3, `busy` falls 3 cycles after `en` low is sampled, and 7 samples remain in the FIFO.
6. Rate change: `div` changed 3->1 mid-period -> the current 4-cycle period completes, after which strobes arrive every 2 cycles with no sample skipped or repeated.
